// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle IF/ID/EX/MEM/WB control FSM for the 16-bit RISC core.
// Each opcode walks only the stages it needs. The PC/IR/regfile/dmem commit
// enables are decoded from the current stage. They are gated by the ready
// input owned by that stage, and forced low while reset is high.
// Optional feature: define PERF_CNT_EN to build the cycle and retired-instruction
// counters. Without it, cycleCnt/instCnt are tied to zero and hold no state.
module stage_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  opcode,
   input  logic        regWr,
   input  logic        MemRd,
   input  logic        MemWr,
   input  logic        branchTaken,
   input  logic        instReady,
   input  logic        memReady,
   output logic [2:0]  stage,
   output logic        irWr,
   output logic        pcWr,
   output logic [1:0]  pcSrc,
   output logic        regWrEn,
   output logic        memRdEn,
   output logic        memWrEn,
   output logic [15:0] cycleCnt,
   output logic [15:0] instCnt
);

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   localparam logic [1:0] PC_INC = 2'd0;
   localparam logic [1:0] PC_BR  = 2'd1;
   localparam logic [1:0] PC_JMP = 2'd2;
   localparam logic [1:0] PC_RET = 2'd3;

   logic [2:0] state, state_nxt;

   // Opcode classes. Each class selects one stage path.
   logic is_alu, is_load, is_store, is_branch, is_jmp, is_call, is_ret;

   // Classify the IR opcode into its stage-path family
   always_comb begin
      is_alu    = (opcode <= 4'd4);
      is_load   = (opcode == 4'd5) || (opcode == 4'd6);
      is_store  = (opcode == 4'd7) || (opcode == 4'd15);
      is_branch = (opcode[3:2] == 2'b10);
      is_jmp    = (opcode == 4'd12);
      is_call   = (opcode == 4'd13);
      is_ret    = (opcode == 4'd14);
   end

   // State register; reset abandons any in-flight instruction and returns to IF
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IF;
      else       state <= state_nxt;
   end

   // Next-state: each stage either stalls on its ready input, advances, or retires to IF
   always_comb begin
      state_nxt = S_IF;
      case (state)
         S_IF:  state_nxt = instReady ? S_ID : S_IF;
         S_ID: begin
            if (is_call)                                   state_nxt = S_WB;
            else if (is_jmp || is_ret)                     state_nxt = S_IF;
            else if (is_alu || is_load || is_store || is_branch) state_nxt = S_EX;
            else                                           state_nxt = S_IF;
         end
         S_EX: begin
            if (is_alu)                   state_nxt = S_WB;
            else if (is_load || is_store) state_nxt = S_MEM;
            else                          state_nxt = S_IF;
         end
         S_MEM: begin
            if (!memReady)    state_nxt = S_MEM;
            else if (is_load) state_nxt = S_WB;
            else              state_nxt = S_IF;
         end
         S_WB:  state_nxt = S_IF;
         default: state_nxt = S_IF;
      endcase
   end

   // Moore-style commit enables. Reset masks them so nothing commits while it is held.
   always_comb begin
      irWr    = 1'b0;
      pcWr    = 1'b0;
      pcSrc   = PC_INC;
      regWrEn = 1'b0;
      memRdEn = 1'b0;
      memWrEn = 1'b0;
      if (!reset) begin
         case (state)
            S_IF: begin
               irWr = instReady;
               pcWr = instReady;
            end
            S_ID: begin
               if (is_jmp || is_call) begin
                  pcWr  = 1'b1;
                  pcSrc = PC_JMP;
               end else if (is_ret) begin
                  pcWr  = 1'b1;
                  pcSrc = PC_RET;
               end
            end
            S_EX: begin
               // A not-taken branch keeps the PC+1 already loaded in IF.
               if (is_branch && branchTaken) begin
                  pcWr  = 1'b1;
                  pcSrc = PC_BR;
               end
            end
            S_MEM: begin
               memRdEn = MemRd;
               memWrEn = MemWr;
            end
            S_WB: regWrEn = regWr;
            default: ;
         endcase
      end
   end

   assign stage = state;

`ifdef PERF_CNT_EN
   logic        retire;
   logic [15:0] cyc_q, inst_q;

   // An instruction retires on the edge that takes a non-IF stage back to IF
   assign retire = (state != S_IF) && (state_nxt == S_IF);

   // Free-running cycle counter and retired-instruction counter, both wrap at 16 bits
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q  <= 16'd0;
         inst_q <= 16'd0;
      end else begin
         cyc_q <= cyc_q + 16'd1;
         if (retire) inst_q <= inst_q + 16'd1;
      end
   end

   assign cycleCnt = cyc_q;
   assign instCnt  = inst_q;
`else
   assign cycleCnt = 16'd0;
   assign instCnt  = 16'd0;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed per-cycle checks of stage paths, commit enables,
// stalls, mid-instruction reset and (with PERF_CNT_EN) the performance counters.
module tb_stage_sequencer;
   logic        clk, reset;
   logic [3:0]  opcode;
   logic        regWr, MemRd, MemWr, branchTaken, instReady, memReady;
   logic [2:0]  stage;
   logic        irWr, pcWr, regWrEn, memRdEn, memWrEn;
   logic [1:0]  pcSrc;
   logic [15:0] cycleCnt, instCnt;

   int checks;
   int failures;
   int exp_inst;

`ifdef PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   stage_sequencer dut (
      .clk(clk), .reset(reset), .opcode(opcode), .regWr(regWr), .MemRd(MemRd),
      .MemWr(MemWr), .branchTaken(branchTaken), .instReady(instReady),
      .memReady(memReady), .stage(stage), .irWr(irWr), .pcWr(pcWr), .pcSrc(pcSrc),
      .regWrEn(regWrEn), .memRdEn(memRdEn), .memWrEn(memWrEn),
      .cycleCnt(cycleCnt), .instCnt(instCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {stage, irWr, pcWr, pcSrc, regWrEn, memRdEn, memWrEn}
   wire [10:0] obs = {stage, irWr, pcWr, pcSrc, regWrEn, memRdEn, memWrEn};

   function automatic logic [10:0] ev(input int st, input bit ir, input bit pw, input int src,
                                      input bit rw, input bit mr, input bit mw);
      logic [2:0] s3;
      logic [1:0] p2;
      s3 = st[2:0];
      p2 = src[1:0];
      return {s3, ir, pw, p2, rw, mr, mw};
   endfunction

   task automatic test_reset();
      reset = 1'b1; opcode = 4'd0; regWr = 1'b1; MemRd = 1'b1; MemWr = 1'b1;
      branchTaken = 1'b1; instReady = 1'b1; memReady = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (obs !== ev(0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL reset_outputs obs=%b exp=%b", obs, ev(0,0,0,0,0,0,0));
      end
      checks++;
      if (cycleCnt !== 16'd0 || instCnt !== 16'd0) begin
         failures++; $display("FAIL reset_counters cyc=%0d inst=%0d exp=0/0", cycleCnt, instCnt);
      end
      @(posedge clk); #1;
      reset = 1'b0; MemRd = 1'b0; MemWr = 1'b0;
   endtask

   task automatic test_alu();
      logic [10:0] e [4];
      e = '{ev(0,1,1,0,0,0,0), ev(1,0,0,0,0,0,0), ev(2,0,0,0,0,0,0), ev(4,0,0,0,1,0,0)};
      opcode = 4'b0000; regWr = 1'b1; MemRd = 1'b0; MemWr = 1'b0;
      instReady = 1'b1; memReady = 1'b1; branchTaken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== e[i]) begin
            failures++; $display("FAIL alu cyc%0d obs=%b exp=%b", i, obs, e[i]);
         end
         @(posedge clk); #1;
      end
      exp_inst++;
      checks++;
      if (stage !== 3'd0) begin
         failures++; $display("FAIL alu_back_to_if stage=%0d exp=0", stage);
      end
      checks++;
      if (cycleCnt !== (PERF ? 16'd4 : 16'd0) || instCnt !== (PERF ? 16'd1 : 16'd0)) begin
         failures++;
         $display("FAIL alu_counters cyc=%0d inst=%0d exp=%0d/%0d", cycleCnt, instCnt,
                  PERF ? 4 : 0, PERF ? 1 : 0);
      end
   endtask

   task automatic test_load();
      logic [10:0] e [7];
      logic [2:0]  ctl [7];   // {instReady, memReady, branchTaken}
      e   = '{ev(0,1,1,0,0,0,0), ev(1,0,0,0,0,0,0), ev(2,0,0,0,0,0,0), ev(3,0,0,0,0,1,0),
              ev(3,0,0,0,0,1,0), ev(3,0,0,0,0,1,0), ev(4,0,0,0,1,0,0)};
      ctl = '{3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b111, 3'b111};
      opcode = 4'b0101; regWr = 1'b1; MemRd = 1'b1; MemWr = 1'b0;
      for (int i = 0; i < 7; i++) begin
         {instReady, memReady, branchTaken} = ctl[i];
         @(negedge clk);
         checks++;
         if (obs !== e[i]) begin
            failures++; $display("FAIL load cyc%0d obs=%b exp=%b", i, obs, e[i]);
         end
         @(posedge clk); #1;
      end
      exp_inst++;
      MemRd = 1'b0;
   endtask

   task automatic test_branch();
      logic [10:0] e [7];
      logic [2:0]  ctl [7];
      logic [3:0]  op [7];
      // taken BEQ with one IF stall, then a not-taken 1011
      e   = '{ev(0,0,0,0,0,0,0), ev(0,1,1,0,0,0,0), ev(1,0,0,0,0,0,0), ev(2,0,1,1,0,0,0),
              ev(0,1,1,0,0,0,0), ev(1,0,0,0,0,0,0), ev(2,0,0,0,0,0,0)};
      ctl = '{3'b000, 3'b101, 3'b101, 3'b001, 3'b110, 3'b010, 3'b010};
      op  = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1011, 4'b1011, 4'b1011};
      regWr = 1'b1; MemRd = 1'b1; MemWr = 1'b1;
      for (int i = 0; i < 7; i++) begin
         opcode = op[i];
         {instReady, memReady, branchTaken} = ctl[i];
         @(negedge clk);
         checks++;
         if (obs !== e[i]) begin
            failures++; $display("FAIL branch cyc%0d obs=%b exp=%b", i, obs, e[i]);
         end
         @(posedge clk); #1;
      end
      exp_inst += 2;
      MemRd = 1'b0; MemWr = 1'b0;
   endtask

   task automatic test_call_ret();
      logic [10:0] e [7];
      logic [3:0]  op [7];
      // CALL, RET, JMP
      e  = '{ev(0,1,1,0,0,0,0), ev(1,0,1,2,0,0,0), ev(4,0,0,0,1,0,0),
             ev(0,1,1,0,0,0,0), ev(1,0,1,3,0,0,0),
             ev(0,1,1,0,0,0,0), ev(1,0,1,2,0,0,0)};
      op = '{4'b1101, 4'b1101, 4'b1101, 4'b1110, 4'b1110, 4'b1100, 4'b1100};
      regWr = 1'b1; instReady = 1'b1; memReady = 1'b1; branchTaken = 1'b1;
      for (int i = 0; i < 7; i++) begin
         opcode = op[i];
         @(negedge clk);
         checks++;
         if (obs !== e[i]) begin
            failures++; $display("FAIL call_ret cyc%0d obs=%b exp=%b", i, obs, e[i]);
         end
         @(posedge clk); #1;
      end
      exp_inst += 3;
   endtask

   task automatic test_store();
      logic [10:0] e [9];
      logic [2:0]  ctl [9];
      logic [3:0]  op [9];
      // SW with no wait, SV with one MEM wait state
      e   = '{ev(0,1,1,0,0,0,0), ev(1,0,0,0,0,0,0), ev(2,0,0,0,0,0,0), ev(3,0,0,0,0,0,1),
              ev(0,1,1,0,0,0,0), ev(1,0,0,0,0,0,0), ev(2,0,0,0,0,0,0), ev(3,0,0,0,0,0,1),
              ev(3,0,0,0,0,0,1)};
      ctl = '{3'b101, 3'b001, 3'b001, 3'b111, 3'b100, 3'b011, 3'b011, 3'b000, 3'b110};
      op  = '{4'b0111, 4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
      regWr = 1'b1; MemRd = 1'b0; MemWr = 1'b1;
      for (int i = 0; i < 9; i++) begin
         opcode = op[i];
         {instReady, memReady, branchTaken} = ctl[i];
         @(negedge clk);
         checks++;
         if (obs !== e[i]) begin
            failures++; $display("FAIL store cyc%0d obs=%b exp=%b", i, obs, e[i]);
         end
         @(posedge clk); #1;
      end
      exp_inst += 2;
      MemWr = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [10:0] e [4];
      e = '{ev(0,1,1,0,0,0,0), ev(1,0,0,0,0,0,0), ev(2,0,0,0,0,0,0), ev(4,0,0,0,0,0,0)};
      opcode = 4'b0100; regWr = 1'b0; instReady = 1'b1; memReady = 1'b0; branchTaken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (obs !== e[i]) begin
            failures++; $display("FAIL andi cyc%0d obs=%b exp=%b", i, obs, e[i]);
         end
         @(posedge clk); #1;
      end
      exp_inst++;
      checks++;
      if (instCnt !== (PERF ? exp_inst[15:0] : 16'd0)) begin
         failures++;
         $display("FAIL inst_total inst=%0d exp=%0d", instCnt, PERF ? exp_inst : 0);
      end
   endtask

   task automatic test_reset_mid();
      opcode = 4'b0111; regWr = 1'b0; MemWr = 1'b1; instReady = 1'b1; memReady = 1'b1;
      branchTaken = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      @(negedge clk);
      checks++;
      if (obs !== ev(2,0,0,0,0,0,0)) begin
         failures++; $display("FAIL mid_reach_ex obs=%b exp=%b", obs, ev(2,0,0,0,0,0,0));
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (obs !== ev(0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL mid_reset_now obs=%b exp=%b", obs, ev(0,0,0,0,0,0,0));
      end
      checks++;
      if (cycleCnt !== 16'd0 || instCnt !== 16'd0) begin
         failures++; $display("FAIL mid_reset_counters cyc=%0d inst=%0d exp=0/0", cycleCnt, instCnt);
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== ev(0,0,0,0,0,0,0)) begin
         failures++; $display("FAIL mid_reset_hold obs=%b exp=%b", obs, ev(0,0,0,0,0,0,0));
      end
      @(posedge clk); #1;
      reset = 1'b0;
      MemWr = 1'b0;
   endtask

   task automatic test_wrap();
      reset = 1'b1; instReady = 1'b0; opcode = 4'd0;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (65535) @(posedge clk);
      #1;
      checks++;
      if (cycleCnt !== (PERF ? 16'hFFFF : 16'd0)) begin
         failures++; $display("FAIL wrap_max cyc=%h exp=%h", cycleCnt, PERF ? 16'hFFFF : 16'h0);
      end
      @(posedge clk); #1;
      checks++;
      if (cycleCnt !== 16'd0 || instCnt !== 16'd0 || stage !== 3'd0) begin
         failures++;
         $display("FAIL wrap_zero cyc=%h inst=%0d stage=%0d exp=0000/0/0", cycleCnt, instCnt, stage);
      end
   endtask

   initial begin
      checks = 0; failures = 0; exp_inst = 0;
      test_reset();
      test_alu();
      test_load();
      test_branch();
      test_call_ret();
      test_store();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multi-cycle control sequencer for the 16-bit RISC core. Steps each instruction through IF, ID, EX, MEM and WB, skipping the stages its opcode does not need. Consumes the instruction-register opcode and the main decoder's level strobes (regWr, MemRd, MemWr). Produces the per-cycle write enables that commit PC, IR, register file and data memory, each in the correct stage.

## Interface
Parameters: none.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; forces state IF and clears counters.
- opcode  in  4  IR[15:12]; stable from ID until the instruction completes.
- regWr  in  1  decoder register-write strobe (level).
- MemRd  in  1  decoder data-memory read strobe (level).
- MemWr  in  1  decoder data-memory write strobe (level).
- branchTaken  in  1  comparator result; valid in EX.
- instReady  in  1  instruction memory done; IF completes only when high.
- memReady  in  1  data memory done; MEM completes only when high.
- stage  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4.
- irWr  out  1  load IR.
- pcWr  out  1  load PC.
- pcSrc  out  2  PC source: 0 = PC+1, 1 = branch target, 2 = jump/call target, 3 = R7 (return).
- regWrEn  out  1  register-file write enable.
- memRdEn  out  1  data-memory read request.
- memWrEn  out  1  data-memory write request.
- cycleCnt  out  16  clock-cycle counter (see Configuration).
- instCnt  out  16  retired-instruction counter (see Configuration).

## Operation
Stage paths by opcode:
- 0000–0100 (R-type, ADDI, ANDI): IF→ID→EX→WB.
- 0101, 0110 (LW, LB): IF→ID→EX→MEM→WB.
- 0111, 1111 (SW, SV): IF→ID→EX→MEM.
- 1000–1011 (branches): IF→ID→EX.
- 1100 (JMP), 1110 (RET): IF→ID.
- 1101 (CALL): IF→ID→WB.

After the last stage of every path, the next state is IF.

Outputs are Moore-style from state, gated by the ready inputs:
- IF: irWr = pcWr = instReady, pcSrc=0. Remain in IF while instReady=0.
- ID: JMP and CALL assert pcWr with pcSrc=2; RET asserts pcWr with pcSrc=3. All other opcodes leave pcWr=0.
- EX: branches assert pcWr = branchTaken with pcSrc=1. A not-taken branch keeps the PC+1 value already loaded in IF.
- MEM: memRdEn = MemRd and memWrEn = MemWr for the whole stage. Remain in MEM while memReady=0; exit on the first cycle memReady=1.
- WB: regWrEn = regWr for exactly one cycle.

In every cycle, any enable not listed for that state is 0. pcSrc is 0 whenever pcWr=0.

## Timing
- Reset: stage=0 (IF). While reset is high, irWr, pcWr, regWrEn, memRdEn and memWrEn are 0, pcSrc=0, and both counters are 0. Reset asserted mid-instruction abandons the instruction immediately, with no partial commit after the assertion edge.
- First fetch begins in the first cycle after reset deasserts.
- CPI with zero wait states: ALU 4, load 5, store 4, branch 3, JMP/RET 2, CALL 3.
- Each cycle with instReady=0 in IF, or memReady=0 in MEM, adds one cycle; the strobes hold steady throughout.
- Ready inputs are ignored in every state other than the one that samples them.
- If a stall and branchTaken coincide, no conflict arises: they belong to different states.

## Configuration
- PERF_CNT_EN defined:
  - cycleCnt increments every cycle after reset.
  - instCnt increments on each clock edge that transitions the FSM back into IF from a final stage.
  - Both counters are 16-bit and wrap from 0xFFFF to 0x0000.
- PERF_CNT_EN undefined: both ports remain present and are tied to 0; no counter registers are synthesized.

## Test plan
- Release reset with instReady=1 and opcode=0000 held → stage sequence 0,1,2,4,0; irWr=pcWr=1 only in IF; regWrEn=1 only in WB; with PERF_CNT_EN, instCnt=1 after 4 cycles.
- LW (0101), MemRd=1, memReady low for 2 cycles → MEM lasts 3 cycles with memRdEn=1 throughout; WB has regWrEn=1; total 7 cycles.
- BEQ-type (1000) with branchTaken=1, then again with branchTaken=0 → taken case: pcWr=1, pcSrc=1 in EX; not-taken case: pcWr=0 in EX; each instruction takes 3 cycles.
- CALL (1101) with regWr=1, then RET (1110) → CALL: ID pcWr=1, pcSrc=2, then WB regWrEn=1. RET: ID pcWr=1, pcSrc=3, 2 cycles.
- SW (0111) with reset asserted in EX → stage=0 immediately; memWrEn never asserts; counters read 0.
- PERF_CNT_EN defined, 65536 cycles with instReady held 0 → cycleCnt wraps to 0x0000 and instCnt stays 0.
